shift_left_unit: RTL and testbench

Registered 64-bit logical left shifter for the datapath (e.g. scaling word offsets into byte addresses before the branch/jump adder). It accepts one operand per cycle with a shift amount, and returns the shifted word one clock later with a valid flag, the bits shifted out, and an overflow flag. It is a leaf block with no memory beyond its output registers.

---
 rtl/shift_left_unit.sv | 66 ++++++
 tb/tb_shift_left_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shift_left_unit.sv
// Registered logical left shifter: returns the shifted word, the bits pushed off
// the MSB end (right-aligned) and an overflow flag one clock after acceptance.
module shift_left_unit #(
    parameter  int WIDTH         = 64,
    parameter  int DEFAULT_SHAMT = 2,
    localparam int SW            = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_input,
    input  logic             use_shamt,
    input  logic [SW-1:0]    shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_output,
    output logic [WIDTH-1:0] shifted_out,
    output logic             overflow
);

    localparam logic [SW-1:0] DEFAULT_K = SW'(DEFAULT_SHAMT);

    logic [SW-1:0]        w_amount;
    logic [2*WIDTH-1:0]   w_stage [0:SW];
    logic [WIDTH-1:0]     w_data_next;
    logic [WIDTH-1:0]     w_shout_next;

    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic [WIDTH-1:0]     r_shout;
    logic                 r_ovf;

    assign w_amount = use_shamt ? shamt : DEFAULT_K;

    // Shifting {zeros, operand} as one double-width word makes the upper half
    // collect exactly the discarded bits, so one barrel serves both paths.
    assign w_stage[0] = {{WIDTH{1'b0}}, data_input};

    for (genvar g = 0; g < SW; g++) begin : g_stage
        assign w_stage[g+1] = w_amount[g] ? (w_stage[g] << (2**g)) : w_stage[g];
    end

    assign w_data_next  = w_stage[SW][WIDTH-1:0];
    assign w_shout_next = w_stage[SW][2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shout <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data  <= w_data_next;
                r_shout <= w_shout_next;
                r_ovf   <= |w_shout_next;
            end
        end
    end

    assign out_valid   = r_valid;
    assign data_output = r_data;
    assign shifted_out = r_shout;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_shift_left_unit.sv
// Directed and random checks of shift_left_unit against hand-computed values
// and a plain <<, >> reference model.
module tb_shift_left_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] data_input;
    logic        use_shamt;
    logic [5:0]  shamt;
    logic        out_valid;
    logic [63:0] data_output;
    logic [63:0] shifted_out;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    logic        e_valid;
    logic [63:0] e_data, e_shout, m_data, m_shout;
    logic        e_ovf;

    always #5 clk = ~clk;

    shift_left_unit #(.WIDTH(64), .DEFAULT_SHAMT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .data_input  (data_input),
        .use_shamt   (use_shamt),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .data_output (data_output),
        .shifted_out (shifted_out),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [63:0] d,
                           input logic [63:0] s, input logic o);
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({tag, ".data"},  data_output, d);
        chk({tag, ".shout"}, shifted_out, s);
        chk({tag, ".ovf"},   {63'd0, overflow}, {63'd0, o});
    endtask

    task automatic model(input logic [63:0] d, input int k,
                         output logic [63:0] o, output logic [63:0] s);
        o = d << k;
        s = (k == 0) ? 64'd0 : (d >> (64 - k));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        use_shamt  = 1'b1;
        data_input = {$urandom, $urandom};
        shamt      = 6'($urandom);

        // reset dominates in_valid
        step();
        chk_all("rst0", 1'b0, 64'd0, 64'd0, 1'b0);
        data_input = {$urandom, $urandom};
        shamt      = 6'($urandom);
        step();
        chk_all("rst1", 1'b0, 64'd0, 64'd0, 1'b0);

        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        chk_all("idle", 1'b0, 64'd0, 64'd0, 1'b0);

        in_valid   = 1'b1;
        use_shamt  = 1'b0;
        data_input = 64'h3;
        step();
        chk_all("def3", 1'b1, 64'hC, 64'd0, 1'b0);
        data_input = 64'hB;
        step();
        chk_all("defB", 1'b1, 64'h2C, 64'd0, 1'b0);

        use_shamt  = 1'b1;
        data_input = 64'h8000_0000_0000_0001;
        shamt      = 6'd0;
        step();
        chk_all("k0", 1'b1, 64'h8000_0000_0000_0001, 64'd0, 1'b0);
        shamt = 6'd1;
        step();
        chk_all("k1", 1'b1, 64'h2, 64'h1, 1'b1);
        shamt = 6'd63;
        step();
        chk_all("k63", 1'b1, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1);

        data_input = 64'hFF;
        for (int i = 0; i < 8; i++) begin
            shamt = 6'(i);
            step();
            chk_all($sformatf("b2b%0d", i), 1'b1, 64'hFF << i, 64'd0, 1'b0);
        end

        in_valid   = 1'b0;
        data_input = 64'hDEAD_BEEF_0000_FFFF;
        step();
        chk_all("hold0", 1'b0, 64'h7F80, 64'd0, 1'b0);
        data_input = ~data_input;
        step();
        chk_all("hold1", 1'b0, 64'h7F80, 64'd0, 1'b0);

        // reset arriving with a valid operand discards it
        in_valid   = 1'b1;
        use_shamt  = 1'b0;
        data_input = 64'hC000_0000_0000_0005;
        rst_n      = 1'b0;
        step();
        chk_all("midrst", 1'b0, 64'd0, 64'd0, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        chk_all("postrst", 1'b0, 64'd0, 64'd0, 1'b0);
        in_valid = 1'b1;
        step();
        chk_all("firstres", 1'b1, 64'h14, 64'h3, 1'b1);

        e_valid = 1'b1;
        e_data  = 64'h14;
        e_shout = 64'h3;
        e_ovf   = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            int k;
            in_valid   = ($urandom_range(0, 3) != 0);
            use_shamt  = 1'($urandom);
            shamt      = 6'($urandom);
            data_input = {$urandom, $urandom};
            k = use_shamt ? int'(shamt) : 2;
            model(data_input, k, m_data, m_shout);
            step();
            e_valid = in_valid;
            if (in_valid) begin
                e_data  = m_data;
                e_shout = m_shout;
                e_ovf   = (m_shout != 64'd0);
            end
            chk_all("rand", e_valid, e_data, e_shout, e_ovf);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
